// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among several producers.
// A grant is held for up to C_BURST_LEN beats so a producer's data stays contiguous.
module fifo_write_arbiter #(
    parameter int C_DATA_WIDTH = 8,
    parameter int C_NUM_REQ    = 4,
    parameter int C_BURST_LEN  = 4
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [C_NUM_REQ-1:0]              req_valid,
    output logic [C_NUM_REQ-1:0]              req_ready,
    input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] req_data,
    output logic                              write_valid,
    input  logic                              write_ready,
    output logic [C_DATA_WIDTH-1:0]           write_data,
    output logic                              grant_active,
    output logic [$clog2(C_NUM_REQ)-1:0]      grant_id
);

    localparam int IW = $clog2(C_NUM_REQ);
    localparam int CW = $clog2(C_BURST_LEN + 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     g_q, g_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     cnt_inc;

    logic              hi_found, lo_found, found;
    logic [IW-1:0]     hi_idx, lo_idx, win;

    logic                    sel_valid;
    logic [C_DATA_WIDTH-1:0] sel_data;
    logic [C_NUM_REQ-1:0]    sel_ready;

    // Two-pass search: indices at or above ptr first, then the wrapped ones.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < C_NUM_REQ; i++) begin
            if (req_valid[i]) begin
                if (IW'(i) >= ptr_q) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = IW'(i);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = IW'(i);
                end
            end
        end
        found = hi_found | lo_found;
        win   = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_ready = '0;
        for (int i = 0; i < C_NUM_REQ; i++) begin
            if (g_q == IW'(i)) begin
                sel_valid    = req_valid[i];
                sel_data     = req_data[i*C_DATA_WIDTH +: C_DATA_WIDTH];
                sel_ready[i] = write_ready;
            end
        end
    end

    // Outputs are forced low during reset so no handshake can complete.
    always_comb begin
        req_ready    = '0;
        write_valid  = 1'b0;
        write_data   = '0;
        grant_active = 1'b0;
        grant_id     = '0;
        if (resetn && state_q == S_GRANT) begin
            req_ready    = sel_ready;
            write_valid  = sel_valid;
            write_data   = sel_data;
            grant_active = 1'b1;
            grant_id     = g_q;
        end
    end

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_GRANT;
                    g_d     = win;
                    cnt_d   = '0;
                end
            end
            S_GRANT: begin
                if (!sel_valid ||
                    (write_ready && cnt_inc == CW'(C_BURST_LEN))) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    ptr_d   = (g_q == IW'(C_NUM_REQ - 1)) ? '0 : g_q + 1'b1;
                end else if (write_ready) begin
                    cnt_d = cnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: producer queues, FIFO-side log,
// per-cycle grant trace compared against hand-derived sequences.
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic        write_valid;
    logic        write_ready;
    logic [7:0]  write_data;
    logic        grant_active;
    logic [1:0]  grant_id;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .C_DATA_WIDTH(8),
        .C_NUM_REQ(4),
        .C_BURST_LEN(4)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data(req_data),
        .write_valid(write_valid),
        .write_ready(write_ready),
        .write_data(write_data),
        .grant_active(grant_active),
        .grant_id(grant_id)
    );

    int checks = 0;
    int errors = 0;
    int idle_bad = 0;

    logic [7:0]   pdat [4][16];
    int           pcnt [4];
    int           phead [4];
    logic [3:0]   en;
    logic [255:0] trc;
    logic [255:0] wpk;
    int           wn;

    logic       s_wv, s_ga;
    logic [3:0] s_rr;
    logic [1:0] s_gid;
    logic [7:0] s_wd;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic apply();
        logic has;
        for (int i = 0; i < 4; i++) begin
            has = phead[i] < pcnt[i];
            req_valid[i] = en[i] && has;
            req_data[i*8 +: 8] = has ? pdat[i][phead[i][3:0]] : 8'h00;
        end
    endtask

    task automatic push(input int p, input logic [7:0] d);
        pdat[p][pcnt[p][3:0]] = d;
        pcnt[p]++;
    endtask

    task automatic clr();
        for (int i = 0; i < 4; i++) begin
            pcnt[i]  = 0;
            phead[i] = 0;
        end
        en  = 4'hF;
        trc = '0;
        wpk = '0;
        wn  = 0;
        apply();
    endtask

    // Sample at negedge, let the edge happen, then advance producers.
    task automatic cyc();
        logic       fire;
        logic [3:0] pop;
        @(negedge clk);
        s_wv  = write_valid;
        s_rr  = req_ready;
        s_ga  = grant_active;
        s_gid = grant_id;
        s_wd  = write_data;
        fire  = write_valid && write_ready;
        pop   = req_ready & req_valid;
        trc   = {trc[251:0], s_ga ? {2'b00, s_gid} : 4'hF};
        if (!s_ga && (s_gid != 0 || s_wv || s_rr != 0 || s_wd != 0))
            idle_bad++;
        @(posedge clk);
        #1;
        if (fire) begin
            wpk = {wpk[247:0], s_wd};
            wn++;
        end
        for (int i = 0; i < 4; i++)
            if (pop[i]) phead[i]++;
        apply();
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    initial begin
        resetn      = 1'b0;
        write_ready = 1'b1;
        clr();
        push(0, 8'h55);
        apply();
        cyc();
        cyc();
        chk("rst_wv", s_wv, 0);
        chk("rst_rdy", s_rr, 0);
        chk("rst_ga", s_ga, 0);
        chk("rst_gid", s_gid, 0);
        chk("rst_wd", s_wd, 0);
        clr();
        resetn = 1'b1;

        // single producer, three beats
        push(2, 8'h61);
        push(2, 8'h62);
        push(2, 8'h63);
        apply();
        run(6);
        chk("t1_trace", trc, 'hF2222F);
        chk("t1_data", wpk, 'h616263);
        chk("t1_n", wn, 3);

        // ptr=3: producer 3 before 0
        clr();
        push(3, 8'hD3);
        push(0, 8'hD0);
        apply();
        run(7);
        chk("t1_ptr_trace", trc, 'hF33F00F);
        chk("t1_ptr_data", wpk, 'hD3D0);

        // ptr=1: producer 3 before 0
        clr();
        push(3, 8'hD3);
        push(0, 8'hD0);
        apply();
        run(7);
        chk("t4_trace", trc, 'hF33F00F);
        chk("t4_data", wpk, 'hD3D0);

        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        clr();

        // all four producers, six beats each
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 6; k++)
                push(i, 8'(i * 16 + k));
        apply();
        run(37);
        chk("t2_trace", trc, 'hF0000F1111F2222F3333F000F111F222F333F);
        chk("t2_data", wpk,
            'h00010203_10111213_20212223_30313233_0405_1415_2425_3435);
        chk("t2_n", wn, 24);

        // backpressure after the first beat
        clr();
        for (int k = 0; k < 5; k++)
            push(0, 8'(8'h61 + k));
        apply();
        run(2);
        write_ready = 1'b0;
        run(5);
        chk("t3_stall_rdy", s_rr, 0);
        chk("t3_stall_wv", s_wv, 1);
        chk("t3_stall_n", wn, 1);
        write_ready = 1'b1;
        run(7);
        chk("t3_trace", trc, 'hF000000000F00F);
        chk("t3_data", wpk, 'h6162636465);
        chk("t3_n", wn, 5);

        // reset mid-burst with producer 1 at cnt=2
        clr();
        for (int k = 0; k < 7; k++)
            push(1, 8'(8'hA0 + k));
        apply();
        run(8);
        resetn = 1'b0;
        cyc();
        chk("t5_rst_wv", s_wv, 0);
        chk("t5_rst_rdy", s_rr, 0);
        chk("t5_rst_ga", s_ga, 0);
        resetn = 1'b1;
        push(3, 8'hB0);
        apply();
        run(7);
        chk("t5_trace", trc, 'hF1111F11FF11F33F);
        chk("t5_data", wpk, 'hA0A1A2A3A4A5A6B0);
        chk("t5_n", wn, 8);

        // valid drop under backpressure
        clr();
        push(2, 8'hC2);
        write_ready = 1'b0;
        apply();
        run(2);
        en[2] = 1'b0;
        apply();
        cyc();
        chk("t6_drop_wv", s_wv, 0);
        chk("t6_drop_ga", s_ga, 1);
        chk("t6_drop_n", wn, 0);
        write_ready = 1'b1;
        en = 4'hF;
        push(0, 8'hC0);
        push(3, 8'hC3);
        apply();
        run(10);
        chk("t6_trace", trc, 'hF22F33F00F22F);
        chk("t6_data", wpk, 'hC3C0C2);
        chk("t6_n", wn, 3);

        chk("idle_outputs", idle_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
